// File: rtl/mem_arbiter_if.sv
// Two-requester memory bus plus the downstream memory port; master drives requests and
// memory responses, slave is the arbiter.
`ifndef ADDR_W
`define ADDR_W              32
`define WORD_W              32
`define MEM_COUNT_W         2
`define MEM_COUNT_NONE      2'd0
`define MEM_COUNT_BYTE      2'd1
`define MEM_COUNT_HALF      2'd2
`define MEM_COUNT_WORD      2'd3
`define MEM_CODE_W          3
`define MEM_CODE_READ       3'd1
`define MEM_CODE_WRITE      3'd2
`define MEM_CODE_MISALIGNED 3'd3
`define MEM_CODE_OUT_OF_BOUNDS 3'd4
`define MEM_CODE_INVALID    3'd5
`endif

interface mem_arbiter_if;
    logic [`ADDR_W-1:0]      i_p0_req_addr;
    logic [`ADDR_W-1:0]      i_p1_req_addr;
    logic [`WORD_W-1:0]      i_p0_req_wr_data;
    logic [`WORD_W-1:0]      i_p1_req_wr_data;
    logic                    i_p0_req_wr_en;
    logic                    i_p1_req_wr_en;
    logic [`MEM_COUNT_W-1:0] i_p0_req_count;
    logic [`MEM_COUNT_W-1:0] i_p1_req_count;
    logic                    o_p0_req_ack;
    logic                    o_p1_req_ack;
    logic                    o_p0_res_valid;
    logic                    o_p1_res_valid;
    logic [`WORD_W-1:0]      o_p0_res_rd_data;
    logic [`WORD_W-1:0]      o_p1_res_rd_data;
    logic [`MEM_CODE_W-1:0]  o_p0_res_code;
    logic [`MEM_CODE_W-1:0]  o_p1_res_code;
    logic [`ADDR_W-1:0]      o_mem_addr;
    logic [`WORD_W-1:0]      o_mem_wr_data;
    logic                    o_mem_wr_en;
    logic [`MEM_COUNT_W-1:0] o_mem_count;
    logic [`WORD_W-1:0]      i_mem_res_rd_data;
    logic [`MEM_CODE_W-1:0]  i_mem_res_code;

    modport master (
        output i_p0_req_addr, i_p1_req_addr, i_p0_req_wr_data, i_p1_req_wr_data,
        output i_p0_req_wr_en, i_p1_req_wr_en, i_p0_req_count, i_p1_req_count,
        input  o_p0_req_ack, o_p1_req_ack, o_p0_res_valid, o_p1_res_valid,
        input  o_p0_res_rd_data, o_p1_res_rd_data, o_p0_res_code, o_p1_res_code,
        input  o_mem_addr, o_mem_wr_data, o_mem_wr_en, o_mem_count,
        output i_mem_res_rd_data, i_mem_res_code
    );

    modport slave (
        input  i_p0_req_addr, i_p1_req_addr, i_p0_req_wr_data, i_p1_req_wr_data,
        input  i_p0_req_wr_en, i_p1_req_wr_en, i_p0_req_count, i_p1_req_count,
        output o_p0_req_ack, o_p1_req_ack, o_p0_res_valid, o_p1_res_valid,
        output o_p0_res_rd_data, o_p1_res_rd_data, o_p0_res_code, o_p1_res_code,
        output o_mem_addr, o_mem_wr_data, o_mem_wr_en, o_mem_count,
        input  i_mem_res_rd_data, i_mem_res_code
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: one outstanding downstream access, fixed MEM_LATENCY response.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 1 wins ties.
`ifndef ADDR_W
`define ADDR_W              32
`define WORD_W              32
`define MEM_COUNT_W         2
`define MEM_COUNT_NONE      2'd0
`define MEM_COUNT_BYTE      2'd1
`define MEM_COUNT_HALF      2'd2
`define MEM_COUNT_WORD      2'd3
`define MEM_CODE_W          3
`define MEM_CODE_READ       3'd1
`define MEM_CODE_WRITE      3'd2
`define MEM_CODE_MISALIGNED 3'd3
`define MEM_CODE_OUT_OF_BOUNDS 3'd4
`define MEM_CODE_INVALID    3'd5
`endif

module mem_arbiter #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input logic          clk,
    input logic          aresetn,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    localparam logic [3:0] LatLast = 4'(MEM_LATENCY);

    state_e     state_q;
    logic [3:0] wait_cnt_q;
    logic       winner_q;
    logic       req0;
    logic       req1;
    logic       tie_to_p1;
    logic       grant1;
    logic       can_ack;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant_q;
    assign tie_to_p1 = ~last_grant_q;
`else
    assign tie_to_p1 = 1'b1;
`endif

    assign req0    = bus.i_p0_req_count != `MEM_COUNT_NONE;
    assign req1    = bus.i_p1_req_count != `MEM_COUNT_NONE;
    assign grant1  = req1 & (~req0 | tie_to_p1);
    // Acks are combinational, so they must also be masked while reset is held.
    assign can_ack = (state_q == StIdle) & aresetn;

    assign bus.o_p0_req_ack = can_ack & req0 & ~grant1;
    assign bus.o_p1_req_ack = can_ack & grant1;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q              <= StIdle;
            wait_cnt_q           <= 4'd0;
            winner_q             <= 1'b0;
            bus.o_mem_addr       <= '0;
            bus.o_mem_wr_data    <= '0;
            bus.o_mem_wr_en      <= 1'b0;
            bus.o_mem_count      <= `MEM_COUNT_NONE;
            bus.o_p0_res_valid   <= 1'b0;
            bus.o_p1_res_valid   <= 1'b0;
            bus.o_p0_res_rd_data <= '0;
            bus.o_p1_res_rd_data <= '0;
            bus.o_p0_res_code    <= '0;
            bus.o_p1_res_code    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q         <= 1'b1;
`endif
        end else begin
            bus.o_p0_res_valid <= 1'b0;
            bus.o_p1_res_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req0 | req1) begin
                        bus.o_mem_addr    <= grant1 ? bus.i_p1_req_addr : bus.i_p0_req_addr;
                        bus.o_mem_wr_data <= grant1 ? bus.i_p1_req_wr_data
                                                    : bus.i_p0_req_wr_data;
                        bus.o_mem_wr_en   <= grant1 ? bus.i_p1_req_wr_en : bus.i_p0_req_wr_en;
                        bus.o_mem_count   <= grant1 ? bus.i_p1_req_count : bus.i_p0_req_count;
                        winner_q          <= grant1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant_q      <= grant1;
`endif
                        state_q           <= StIssue;
                    end
                end
                StIssue: begin
                    // Address and write data stay on the bus; only the strobes are withdrawn.
                    bus.o_mem_count <= `MEM_COUNT_NONE;
                    bus.o_mem_wr_en <= 1'b0;
                    wait_cnt_q      <= 4'd1;
                    state_q         <= StWait;
                end
                StWait: begin
                    if (wait_cnt_q == LatLast) begin
                        if (winner_q) begin
                            bus.o_p1_res_rd_data <= bus.i_mem_res_rd_data;
                            bus.o_p1_res_code    <= bus.i_mem_res_code;
                            bus.o_p1_res_valid   <= 1'b1;
                        end else begin
                            bus.o_p0_res_rd_data <= bus.i_mem_res_rd_data;
                            bus.o_p0_res_code    <= bus.i_mem_res_code;
                            bus.o_p0_res_valid   <= 1'b1;
                        end
                        wait_cnt_q <= 4'd0;
                        state_q    <= StIdle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1, cycles from the downstream issue cycle to the cycle its response is valid; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port aresetn, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have ports i_p0_req_addr, i_p1_req_addr, input, `ADDR_W, requester address (port 0 = fetch, port 1 = data).
REQ-005 SHALL have ports i_p0_req_wr_data, i_p1_req_wr_data, input, `WORD_W, write data.
REQ-006 SHALL have ports i_p0_req_wr_en, i_p1_req_wr_en, input, 1, write enable.
REQ-007 SHALL have ports i_p0_req_count, i_p1_req_count, input, `MEM_COUNT_W, access size; `MEM_COUNT_NONE means no request.
REQ-008 SHALL have ports o_p0_req_ack, o_p1_req_ack, output, 1, combinational accept.
REQ-009 SHALL have ports o_p0_res_valid, o_p1_res_valid, output, 1, one-cycle response strobe.
REQ-010 SHALL have ports o_p0_res_rd_data, o_p1_res_rd_data, output, `WORD_W, and o_p0_res_code, o_p1_res_code, output, `MEM_CODE_W, registered response.
REQ-011 SHALL have ports o_mem_addr, `ADDR_W; o_mem_wr_data, `WORD_W; o_mem_wr_en, 1; o_mem_count, `MEM_COUNT_W, all outputs, registered downstream request.
REQ-012 SHALL have ports i_mem_res_rd_data, `WORD_W, and i_mem_res_code, `MEM_CODE_W, both inputs, downstream response.

Function
REQ-013 SHALL implement states IDLE, ISSUE and WAIT.
REQ-014 SHALL treat a port as requesting when its count != `MEM_COUNT_NONE.
REQ-015 In IDLE with at least one port requesting, SHALL pick a winner, assert only its ack combinationally, latch its addr/wr_data/wr_en/count into o_mem_* at the edge, record the winner, and go to ISSUE.
REQ-016 SHALL keep o_pN_req_ack low outside IDLE, for a non-winning port, and while aresetn is low.
REQ-017 With only one port requesting in IDLE, SHALL grant that port.
REQ-018 In ISSUE, SHALL present the latched request on o_mem_* for exactly one cycle, then drive o_mem_count = `MEM_COUNT_NONE and o_mem_wr_en = 0 and go to WAIT with the wait counter at 1.
REQ-019 In WAIT, SHALL increment the counter each cycle; in the cycle the counter equals MEM_LATENCY, SHALL capture i_mem_res_* into the winner's o_pN_res_rd_data/o_pN_res_code, pulse its o_pN_res_valid for the following cycle, and return to IDLE.
REQ-020 SHALL pass i_mem_res_code through unmodified, including MISALIGNED, OUT_OF_BOUNDS and INVALID.
REQ-021 SHALL hold o_pN_res_rd_data/o_pN_res_code between responses; the loser's outputs SHALL not change.
REQ-022 SHALL ignore request input changes outside IDLE.
REQ-023 SHALL allow a port to be acked in the same cycle its o_pN_res_valid is high.
REQ-024 With MEM_LATENCY = 1, SHALL complete a transaction as: ack at cycle k, issue at k+1, capture at k+2, valid at k+3; this gives a minimum of 3 cycles per transaction.

Reset
REQ-025 On aresetn low, SHALL immediately set: state IDLE; o_mem_addr = 0; o_mem_wr_data = 0; o_mem_wr_en = 0; o_mem_count = `MEM_COUNT_NONE; all o_pN_res_rd_data = 0; all o_pN_res_code = 0; all o_pN_res_valid = 0; wait counter = 0; last-grant register = 1.
REQ-026 A reset during ISSUE or WAIT SHALL drop the transaction with no response strobe to either port.

Configuration
REQ-027 With macro MEM_ARB_ROUND_ROBIN_EN defined, simultaneous requests in IDLE SHALL go to the port not recorded as last grantee; the first tie after reset therefore goes to port 0.
REQ-028 Without MEM_ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always go to port 1, and no last-grant register SHALL be required.

Verification
REQ-029 Port 0 word read of addr 0x10 with downstream returning 0xDEADBEEF/`MEM_CODE_READ -> o_p0_res_valid 3 cycles after ack, rd_data 0xDEADBEEF, code READ; port 1 outputs unchanged.
REQ-030 Both ports request in the same IDLE cycle, RR enabled, after reset -> grants go p0, p1, p0 on successive IDLE cycles; RR disabled -> p1 granted each time while it keeps requesting.
REQ-031 Port 1 byte write, addr 0x3, data 0xAB -> o_mem_* show addr 0x3, wr_en 1, count BYTE for exactly one cycle; p1 gets code `MEM_CODE_WRITE.
REQ-032 MEM_LATENCY = 4, downstream data valid only in the fourth cycle after issue -> captured value is correct and valid arrives 6 cycles after ack.
REQ-033 aresetn pulsed low during WAIT -> no res_valid on either port, all outputs at reset values, and a new request is acked the first cycle after release.
